uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Downstream neighbour of the system controller: accepts a parallel byte on TX_P_DATA/TX_D_VLD.
//  Frames it as start, data (LSB first), optional parity and stop bits.
//  Shifts the frame out on TX_OUT, one bit per baud tick from the clock divider.
//  Busy tells the upstream side when a new byte may be presented.
// PARAMETERS
//  out_width   8   data bits per frame; matches the controller's TX_P_DATA width
// PORTS
//  clk         in   1          system/TX clock, all state on rising edge
//  rst         in   1          asynchronous, active-low reset
//  TICK        in   1          baud-rate enable, 1-clk pulse per bit period (from clk divider)
//  P_DATA      in   out_width  byte to transmit
//  DATA_VALID  in   1          P_DATA valid; accepted only when not Busy
//  PAR_EN      in   1          1 = insert parity bit (only with UART_TX_PARITY_EN)
//  PAR_TYP     in   1          0 = even, 1 = odd parity
//  TX_OUT      out  1          serial line, idle high, registered
//  Busy        out  1          1 from cycle after accept until frame end, registered
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, TX_OUT=1, Busy=0, shift reg=0, bit count=0, parity bit=0.
//  Reset mid-frame aborts immediately: the line goes high, no partial stop.
//  Accept: on clk edge with state IDLE and DATA_VALID=1.
//   - Latches P_DATA, PAR_EN and PAR_TYP; goes to WAIT; Busy=1 the next cycle.
//   - TICK is not required for accept.
//  While Busy=1, DATA_VALID is ignored: no queueing, and upstream must hold its data.
//  FSM; every transition below is taken only on a clk edge with TICK=1, otherwise the state holds:
//   - IDLE   : TX_OUT=1; exits on accept only.
//   - WAIT   : TX_OUT=1 -> START. Aligns the first bit to a full baud period.
//   - START  : TX_OUT=0 -> DATA, count=0.
//   - DATA   : TX_OUT=shift[0]; shift right, count++.
//              At count=out_width-1 -> PARITY if latched PAR_EN (macro on), else STOP.
//   - PARITY : TX_OUT = ^data (even) or ~^data (odd), using the latched data -> STOP.
//   - STOP   : TX_OUT=1. Ends frame -> IDLE, Busy=0 the same edge.
//  Back-to-back: if DATA_VALID=1 on the TICK edge that ends STOP, the byte is latched and the FSM goes straight to START.
//   - Busy stays 1; no extra idle bit is inserted.
//  TX_OUT is registered: the value for each state appears the cycle after the TICK that enters it.
//  Frame length: 10 bit periods without parity, 11 with parity (out_width=8), plus the WAIT alignment.
//  TICK asserted while IDLE has no effect.
//  P_DATA changing after accept has no effect.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - The PARITY state, parity generator and PAR_EN/PAR_TYP sampling are compiled in.
//  Not defined:
//   - PAR_EN and PAR_TYP are ignored; the frame is always start+data+stop.
//   - The PARITY state is unreachable and its logic is removed.
// STRUCTURE
//  Shared package uart_tx_pkg holds:
//   - state encoding localparams: IDLE, WAIT, START, DATA, PARITY, STOP (3 bits);
//   - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
//  Sub-module uart_parity_calc: computes parity from the latched data and PAR_TYP.
//   - Instantiated only under UART_TX_PARITY_EN.
//  The FSM, shifter and counter stay in this module.
// TESTING
//  1. Reset: hold rst=0, toggle TICK -> TX_OUT=1, Busy=0. Release rst -> outputs hold until DATA_VALID.
//  2. P_DATA=0xA5, no parity, TICK every 16 clk -> Busy=1 next clk.
//     Line after WAIT: 0 | 1,0,1,0,0,1,0,1 | 1. Busy=0 after the stop period.
//  3. Macro on, PAR_EN=1:
//     - 0xA5 with PAR_TYP=0 -> parity bit 0, 11-bit frame.
//     - 0xA5 with PAR_TYP=1 -> parity bit 1.
//     - 0x07 with PAR_TYP=0 -> parity bit 1.
//  4. Present 0x3C while Busy=1 -> ignored, frame 1 unchanged.
//     Hold DATA_VALID with 0x3C through the STOP-ending TICK -> START follows the stop with no idle bit, Busy never drops.
//  5. Assert rst=0 in the middle of DATA bit 4 -> TX_OUT=1 and Busy=0 asynchronously.
//     After release, a new 0xFF frame transmits correctly.
//  6. Macro off, PAR_EN=1, 0x00 -> 10-bit frame, no parity bit. TICK gaps of 1 clk and 100 clk -> bits hold exactly one TICK interval.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_pkg                                                  |
// | Description : Shared state encoding and line-level constants for the UART  |
// |               transmit serializer.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_tx_pkg;

  // FSM state encoding (3 bits)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  // Serial line levels
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_parity_calc                                             |
// | Description : Parity bit for one UART frame. Even parity makes the total   |
// |               count of ones (data + parity) even, odd makes it odd.        |
// | Ports       : data    in  WIDTH  latched frame data                        |
// |               par_typ in  1      0 = even, 1 = odd                         |
// |               par_bit out 1      parity bit to place on the line          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par_bit
);

  // Odd parity is the inverse of even parity.
  assign par_bit = (^data) ^ par_typ;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_serializer                                           |
// | Description : Frames a parallel byte as start / data (LSB first) /         |
// |               optional parity / stop and shifts it out one bit per baud    |
// |               TICK. Optional parity is compiled in with the macro          |
// |               UART_TX_PARITY_EN; without it PAR_EN/PAR_TYP are ignored.    |
// | Ports       : clk        in  1          clock, rising edge                 |
// |               rst        in  1          asynchronous reset, active low     |
// |               TICK       in  1          baud enable, 1 clk per bit period  |
// |               P_DATA     in  OUT_WIDTH  byte to transmit                   |
// |               DATA_VALID in  1          P_DATA valid, taken when not busy  |
// |               PAR_EN     in  1          insert parity bit                  |
// |               PAR_TYP    in  1          0 = even, 1 = odd                  |
// |               TX_OUT     out 1          serial line, idle high, registered |
// |               Busy       out 1          frame in progress, registered      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TICK,
  input  logic [OUT_WIDTH-1:0] P_DATA,
  input  logic                 DATA_VALID,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic                 TX_OUT,
  output logic                 Busy
);

  localparam int                c_cnt_w = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(OUT_WIDTH - 1);

  logic [2:0]           r_state;
  logic                 r_tx;
  logic                 r_busy;
  logic [OUT_WIDTH-1:0] r_shift;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_accept;

  // A byte is taken either from IDLE (no TICK needed) or on the TICK that
  // ends STOP, which chains the next frame without an idle bit.
  assign w_accept = DATA_VALID &&
                    ((r_state == IDLE) || ((r_state == STOP) && TICK));

`ifdef UART_TX_PARITY_EN
  // The shifter is consumed bit by bit, so parity works from a separate copy.
  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_par_en;
  logic                 r_par_typ;
  logic                 w_par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data    <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

  uart_parity_calc #(
    .WIDTH   (OUT_WIDTH)
  ) u_parity (
    .data    (r_data),
    .par_typ (r_par_typ),
    .par_bit (w_par_bit)
  );
`else
  logic w_unused;
  assign w_unused = ^{PAR_EN, PAR_TYP};
`endif

  // TX_OUT is loaded with the level of the state being entered, so each
  // bit appears on the line the cycle after the TICK that starts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (w_accept) begin
            r_shift <= P_DATA;
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (TICK) begin
            r_state <= START;
            r_tx    <= START_BIT;
          end
        end
        START: begin
          if (TICK) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_cnt   <= '0;
          end
        end
        DATA: begin
          if (TICK) begin
            if (r_cnt == c_last_cnt) begin
`ifdef UART_TX_PARITY_EN
              if (r_par_en) begin
                r_state <= PARITY;
                r_tx    <= w_par_bit;
              end else begin
                r_state <= STOP;
                r_tx    <= STOP_BIT;
              end
`else
              r_state <= STOP;
              r_tx    <= STOP_BIT;
`endif
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (TICK) begin
            r_state <= STOP;
            r_tx    <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (TICK) begin
            if (w_accept) begin
              r_shift <= P_DATA;
              r_state <= START;
              r_tx    <= START_BIT;
            end else begin
              r_state <= IDLE;
              r_tx    <= IDLE_LEVEL;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_serializer                                        |
// | Description : Directed self-checking bench for uart_tx_serializer.         |
// |               Parity expectations follow UART_TX_PARITY_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_serializer;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       TICK       = 1'b0;
  logic [7:0] P_DATA     = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN     = 1'b0;
  logic       PAR_TYP    = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .OUT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .TICK       (TICK),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic check(input string tag, input int idx, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle TICK pulse; returns 1 time unit after the ticking edge.
  task automatic do_tick();
    TICK = 1'b1;
    idle(1);
    TICK = 1'b0;
  endtask

  // Drives and checks one frame with TICK every `gap` clocks.
  // skip_wait: the frame was already chained into START (line already low).
  // hold_next: present 0x3C during the frame and through the STOP-ending tick.
  task automatic frame(input logic [7:0] data, input logic par_en, input logic par_typ,
                       input logic has_par, input logic exp_par, input int gap,
                       input logic skip_wait, input logic hold_next);
    if (!skip_wait) begin
      P_DATA     = data;
      PAR_EN     = par_en;
      PAR_TYP    = par_typ;
      DATA_VALID = 1'b1;
      idle(1);
      DATA_VALID = 1'b0;
      P_DATA     = ~data;
      check("accept_busy", 0, Busy, 1'b1);
      check("wait_tx", 0, TX_OUT, 1'b1);
      idle(gap - 1);
      do_tick();
      check("start_tx", 0, TX_OUT, 1'b0);
    end
    if (hold_next) begin
      P_DATA     = 8'h3C;
      DATA_VALID = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      idle(gap - 1);
      if (gap > 1)
        check("hold_tx", i, TX_OUT, (i == 0) ? 1'b0 : data[i-1]);
      do_tick();
      check("data_tx", i, TX_OUT, data[i]);
      check("data_busy", i, Busy, 1'b1);
    end
    if (has_par) begin
      idle(gap - 1);
      do_tick();
      check("parity_tx", 0, TX_OUT, exp_par);
    end
    idle(gap - 1);
    do_tick();
    check("stop_tx", 0, TX_OUT, 1'b1);
    check("stop_busy", 0, Busy, 1'b1);
    idle(gap - 1);
    do_tick();
    if (hold_next) begin
      check("chain_start_tx", 0, TX_OUT, 1'b0);
      check("chain_busy", 0, Busy, 1'b1);
      DATA_VALID = 1'b0;
      PAR_EN     = 1'b0;
    end else begin
      check("end_busy", 0, Busy, 1'b0);
      check("end_tx", 0, TX_OUT, 1'b1);
    end
  endtask

  initial begin
    // 1. Reset held: TICK activity must not disturb the idle outputs.
    repeat (3) begin
      TICK = 1'b1;
      idle(1);
      TICK = 1'b0;
      idle(1);
    end
    check("rst_tx", 0, TX_OUT, 1'b1);
    check("rst_busy", 0, Busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    repeat (3) begin
      do_tick();
      idle(2);
    end
    check("idle_tx", 0, TX_OUT, 1'b1);
    check("idle_busy", 0, Busy, 1'b0);

    // 2. 0xA5 without parity.
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0);

    // 3. Parity variants (11-bit frames only when parity is compiled in).
    frame(8'hA5, 1'b1, 1'b0, PAR_BUILD, 1'b0, 16, 1'b0, 1'b0);
    frame(8'hA5, 1'b1, 1'b1, PAR_BUILD, 1'b1, 16, 1'b0, 1'b0);
    frame(8'h07, 1'b1, 1'b0, PAR_BUILD, 1'b1, 16, 1'b0, 1'b0);

    // 4. 0x3C presented while busy is ignored, then chains at the stop tick.
    frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1);
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0);

    // 5. Reset in the middle of data bit 4 of a 0x00 frame.
    P_DATA     = 8'h00;
    DATA_VALID = 1'b1;
    idle(1);
    DATA_VALID = 1'b0;
    idle(15);
    do_tick();
    repeat (5) begin
      idle(15);
      do_tick();
    end
    idle(7);
    check("pre_rst_tx", 0, TX_OUT, 1'b0);
    check("pre_rst_busy", 0, Busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx", 0, TX_OUT, 1'b1);
    check("async_rst_busy", 0, Busy, 1'b0);
    do_tick();
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    check("post_rst_tx", 0, TX_OUT, 1'b1);
    frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0);

    // 6. PAR_EN=1 with 0x00, TICK gaps of 1 and 100 clocks.
    frame(8'h00, 1'b1, 1'b0, PAR_BUILD, 1'b0, 1, 1'b0, 1'b0);
    frame(8'h00, 1'b1, 1'b0, PAR_BUILD, 1'b0, 100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
